// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and state type for the matrix result streamer
package matrix_pkg;

  localparam int MAT_DIM   = 4;
  localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
  localparam int IDX_W     = 4;

  typedef enum logic {
    IDLE,
    STREAM
  } streamer_state_t;

endpackage

// File: rtl/matrix_result_streamer_if.sv
// rtl/matrix_result_streamer_if.sv - element stream handshake bundle with coordinates
interface matrix_result_streamer_if
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0]      m_data;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_last;
  logic [$clog2(MAT_DIM)-1:0] m_row;
  logic [$clog2(MAT_DIM)-1:0] m_col;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_row,
    output m_col,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  m_row,
    input  m_col,
    output m_ready
  );

endinterface

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - snapshots the 4x4 MAC result and drains it row-major
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter bit CLEAR_ON_CAPTURE = 1'b1
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              capture,
  input  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0]   result,
  matrix_result_streamer_if.master                          stream,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              acc_clear,
  output logic                                              capture_drop
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ELEMS - 1);

  streamer_state_t state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_WIDTH-1:0] snap;

  logic load;
  logic done_next;
  logic clear_next;
  logic drop_next;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    done_next  = 1'b0;
    clear_next = 1'b0;
    drop_next  = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = STREAM;
          clear_next = CLEAR_ON_CAPTURE;
        end
      end
      STREAM: begin
        // A capture arriving mid-stream, even on the final beat, is discarded.
        drop_next = capture;
        if (stream.m_ready) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx          <= '0;
      snap         <= '0;
      done         <= 1'b0;
      acc_clear    <= 1'b0;
      capture_drop <= 1'b0;
    end else begin
      idx          <= idx_next;
      done         <= done_next;
      acc_clear    <= clear_next;
      capture_drop <= drop_next;
      if (load) begin
        snap <= result;
      end
    end
  end

  // Outputs decode only registered state, so nothing depends on m_ready combinationally.
  assign busy           = (state == STREAM);
  assign stream.m_valid = busy;
  assign stream.m_last  = busy && (idx == LAST_IDX);
  assign stream.m_row   = idx[3:2];
  assign stream.m_col   = idx[1:0];
  assign stream.m_data  = snap[idx[3:2]][idx[1:0]];

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - randomized bench against a queue-based reference model
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  logic capture;
  logic rdy;
  logic [0:MAT_DIM-1][0:MAT_DIM-1][DW-1:0] result;
  logic [0:MAT_DIM-1][0:MAT_DIM-1][DW-1:0] res_drive;

  logic busy1, done1, clr1, drop1;
  logic busy0, done0, clr0, drop0;

  matrix_result_streamer_if #(.DATA_WIDTH(DW)) s1 ();
  matrix_result_streamer_if #(.DATA_WIDTH(DW)) s0 ();

  matrix_result_streamer #(.DATA_WIDTH(DW), .CLEAR_ON_CAPTURE(1'b1)) dut1 (
    .clock(clk), .reset(rst_n), .capture(capture), .result(result), .stream(s1),
    .busy(busy1), .done(done1), .acc_clear(clr1), .capture_drop(drop1)
  );

  matrix_result_streamer #(.DATA_WIDTH(DW), .CLEAR_ON_CAPTURE(1'b0)) dut0 (
    .clock(clk), .reset(rst_n), .capture(capture), .result(result), .stream(s0),
    .busy(busy0), .done(done0), .acc_clear(clr0), .capture_drop(drop0)
  );

  assign s1.m_ready = rdy;
  assign s0.m_ready = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the pending beats of the current stream, plus expected pulses.
  logic [DW-1:0] q[$];
  bit e_done = 0;
  bit e_drop = 0;
  bit e_clr  = 0;
  bit e_zero = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string who, input logic [DW-1:0] data, input logic valid,
                           input logic last, input logic [1:0] row, input logic [1:0] col,
                           input logic busy, input logic done, input logic clr,
                           input logic drop, input logic exp_clr);
    int pos;
    pos = MAT_ELEMS - q.size();
    check({who, ".valid"}, valid, q.size() != 0);
    check({who, ".busy"}, busy, q.size() != 0);
    check({who, ".done"}, done, e_done);
    check({who, ".drop"}, drop, e_drop);
    check({who, ".clr"}, clr, exp_clr);
    if (q.size() != 0) begin
      check({who, ".data"}, data, q[0]);
      check({who, ".row"}, row, pos / MAT_DIM);
      check({who, ".col"}, col, pos % MAT_DIM);
      check({who, ".last"}, last, q.size() == 1);
    end else begin
      check({who, ".last"}, last, 1'b0);
      if (e_zero) begin
        check({who, ".data0"}, data, '0);
        check({who, ".row0"}, row, 2'd0);
        check({who, ".col0"}, col, 2'd0);
      end
    end
  endtask

  task automatic model_edge();
    bit act;
    if (!rst_n) begin
      q.delete();
      e_done = 0;
      e_drop = 0;
      e_clr  = 0;
      e_zero = 1;
    end else begin
      act    = (q.size() != 0);
      e_done = 0;
      e_clr  = 0;
      e_drop = capture && act;
      if (act && rdy) begin
        void'(q.pop_front());
        e_done = (q.size() == 0);
      end else if (!act && capture) begin
        for (int r = 0; r < MAT_DIM; r++)
          for (int c = 0; c < MAT_DIM; c++)
            q.push_back(result[r][c]);
        e_clr  = 1;
        e_zero = 0;
      end
    end
  endtask

  task automatic step(input logic cap, input logic rd, input logic rn);
    @(negedge clk);
    check_dut("d1", s1.m_data, s1.m_valid, s1.m_last, s1.m_row, s1.m_col,
              busy1, done1, clr1, drop1, e_clr);
    check_dut("d0", s0.m_data, s0.m_valid, s0.m_last, s0.m_row, s0.m_col,
              busy0, done0, clr0, drop0, 1'b0);
    capture = cap;
    rdy     = rd;
    rst_n   = rn;
    result  = res_drive;
    @(posedge clk);
    model_edge();
  endtask

  task automatic set_ramp();
    for (int r = 0; r < MAT_DIM; r++)
      for (int c = 0; c < MAT_DIM; c++)
        res_drive[r][c] = DW'(r * MAT_DIM + c + 1);
  endtask

  bit restarted;
  bit cap_r;

  initial begin
    capture   = 1'b0;
    rdy       = 1'b0;
    rst_n     = 1'b0;
    res_drive = '0;
    result    = '0;

    repeat (3) step(0, 0, 0);
    step(0, 1, 1);

    // Ramp values with ready held high.
    set_ramp();
    step(1, 1, 1);
    repeat (20) step(0, 1, 1);

    // Stalling consumer; result overwritten right after capture.
    step(1, 1, 1);
    res_drive = '1;
    for (int i = 0; i < 52; i++) step(0, (i % 3) == 0, 1);
    set_ramp();

    // Captures mid-stream and on the final beat, then one during the done cycle.
    step(1, 1, 1);
    restarted = 0;
    for (int i = 0; i < 45; i++) begin
      cap_r = (q.size() != 0 && (MAT_ELEMS - q.size()) == 5) || (q.size() == 1);
      if (e_done && !restarted) begin
        cap_r     = 1;
        restarted = 1;
      end
      step(cap_r, 1, 1);
    end

    // Reset in mid-stream at beat 8, then a fresh stream.
    step(1, 1, 1);
    while (q.size() != 0 && (MAT_ELEMS - q.size()) != 8) step(0, 1, 1);
    step(0, 1, 0);
    repeat (3) step(0, 1, 1);
    step(1, 1, 1);
    repeat (20) step(0, 1, 1);

    // Consumer holds ready low for 20 cycles.
    step(1, 0, 1);
    repeat (20) step(0, 0, 1);
    repeat (20) step(0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < MAT_DIM; r++)
        for (int c = 0; c < MAT_DIM; c++)
          res_drive[r][c] = DW'($urandom);
      step(($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 64) != 0);
    end
    repeat (20) step(0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Read-side companion to the matrix MAC unit. On a capture pulse it snapshots the 4x4 `result` matrix and drains it as a row-major stream of 16 elements over a valid/ready handshake, with a last flag and element coordinates. It sits between the MAC's `result` bus and any narrow consumer (FIFO, bus writer, host port). It can optionally pulse a clear request back to the MAC accumulator once the snapshot is taken.

## Interface
- `DATA_WIDTH`, default 8: element width, equal to the MAC's `DATA_WIDTH`.
- `CLEAR_ON_CAPTURE`, default 1: when 1, `acc_clear` pulses on every accepted capture; when 0, `acc_clear` is tied 0.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `capture`  in  1  request to snapshot `result` and start streaming.
- `result`  in  `[DATA_WIDTH-1:0] [0:3][0:3]`  MAC result matrix.
- `m_data`  out  DATA_WIDTH  current element.
- `m_valid`  out  1  `m_data`, `m_row`, `m_col` and `m_last` are valid.
- `m_ready`  in  1  consumer accepts the element when high together with `m_valid`.
- `m_last`  out  1  high with element [3][3].
- `m_row`, `m_col`  out  2 each  coordinates of the current element.
- `busy`  out  1  high while in STREAM.
- `done`  out  1  one-cycle pulse after the final handshake.
- `acc_clear`  out  1  one-cycle pulse on an accepted capture.
- `capture_drop`  out  1  one-cycle pulse when a capture is ignored.

## Operation
- States: IDLE, STREAM.
- Reset (`reset`=0 at an edge):
  - Returns to IDLE.
  - Zeroes the snapshot and the index.
  - Drives `m_valid`, `m_last`, `busy`, `done`, `acc_clear` and `capture_drop` to 0, and `m_data`, `m_row`, `m_col` to 0.
  - Reset wins over every other input, including in mid-stream. No `done` pulse is produced for an aborted stream.
- IDLE with `capture`=1: latch all 16 elements of `result`, set index to 0, go to STREAM. If `CLEAR_ON_CAPTURE`=1, register a pulse on `acc_clear`.
- STREAM:
  - The presented element is snapshot[index/4][index%4], with `m_row`=index[3:2] and `m_col`=index[1:0].
  - `m_last` = (index==15).
  - On a handshake (`m_valid` && `m_ready`): if index<15, increment index; if index==15, go to IDLE and pulse `done` next cycle.
  - With no handshake, all outputs hold stable. `m_valid` never drops without a handshake.
- `capture` while in STREAM is ignored and pulses `capture_drop` next cycle. This includes the cycle of the final handshake: capture is accepted only when the state is IDLE at the sampling edge.
- The snapshot is immune to changes on `result` after capture.
- Values are passed through unmodified; there is no arithmetic on data.
- The index is 4 bits and never wraps within a stream. It is reloaded to 0 on capture.

## Timing
- Capture sampled at edge N:
  - `busy`=1, `m_valid`=1 and element [0][0] appear after edge N.
  - `acc_clear` is high for the cycle after edge N.
- With `m_ready` held at 1, elements [0][0]..[3][3] are accepted at edges N+1..N+16, i.e. one element per cycle.
- After edge N+16: `m_valid`=0, `busy`=0, and `done`=1 for one cycle.
- A new capture is accepted at edge N+17 at the earliest. A capture at N+16 is dropped.
- Each cycle with `m_ready` low extends the stream by one cycle.
- Outputs are registered; `m_valid` and `m_data` have no combinational path from `m_ready`.

## Structure
- Shared package `matrix_pkg` holds:
  - `MAT_DIM`=4 and `MAT_ELEMS`=16.
  - Index width constant (4).
  - `streamer_state_t` enum {IDLE, STREAM}.
- Single module with no sub-module. The snapshot register and the 16:1 element mux are inline.

## Test plan
- Reset, then capture with result[r][c]=r*4+c+1 and `m_ready`=1 -> 16 beats of values 1..16 at consecutive cycles, coordinates (0,0)..(3,3), `m_last` only on value 16, `done` one cycle later, `acc_clear` once.
- Same capture, with `m_ready` toggling 1,0,0,1,... and `result` changed to all 0xFF after capture -> the sequence is still 1..16, and data is stable during stalls.
- Capture asserted again at beat 5 and at the final-handshake cycle -> two `capture_drop` pulses and the stream is unaffected. A capture one cycle after `done` starts a new stream.
- `reset`=0 at beat 8 -> next cycle `m_valid`=0, `busy`=0, no `done`. A following capture streams from (0,0).
- `CLEAR_ON_CAPTURE`=0 -> `acc_clear` never asserts. Capture with `m_ready`=0 for 20 cycles -> `m_valid` held high on element [0][0].
